// File: rtl/traffic_phase_timer.sv
// Phase countdown generator for the traffic light FSM: reloads on each light change, decrements per prescaled tick.
// Optional pedestrian green extension is enabled by defining PED_EXTEND_EN.
module traffic_phase_timer #(
  parameter int TICK_DIV    = 1,
  parameter int RED_TIME    = 3,
  parameter int GREEN_TIME  = 3,
  parameter int YELLOW_TIME = 2
`ifdef PED_EXTEND_EN
  ,
  parameter int PED_EXTRA   = 2
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
`ifdef PED_EXTEND_EN
  input  logic       ped_req,
`endif
  output logic [3:0] timer,
  output logic       expire,
  output logic       tick,
  output logic       fault
);

  if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
    $error("traffic_phase_timer: TICK_DIV must be 1..65535");
  end
  if (RED_TIME < 1 || RED_TIME > 16 || GREEN_TIME < 1 || GREEN_TIME > 16 ||
      YELLOW_TIME < 1 || YELLOW_TIME > 16) begin : g_bad_phase_time
    $error("traffic_phase_timer: phase times must be 1..16");
  end
`ifdef PED_EXTEND_EN
  if (PED_EXTRA < 1 || PED_EXTRA > 15) begin : g_bad_ped_extra
    $error("traffic_phase_timer: PED_EXTRA must be 1..15");
  end
`endif

  localparam logic [2:0]  RED      = 3'b100;
  localparam logic [2:0]  YELLOW   = 3'b010;
  localparam logic [2:0]  GREEN    = 3'b001;
  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {COUNT, HOLD, FAULT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  timer_d;
  logic        expire_d;
  logic [2:0]  prev_q, prev_d;
  logic [15:0] div_q, div_d;
  logic        tick_raw;
  logic        legal;
`ifdef PED_EXTEND_EN
  logic        used_q, used_d;
  logic [4:0]  ped_sum;
`endif

  function automatic logic [3:0] load_val(input logic [2:0] l);
    case (l)
      GREEN:   return 4'(GREEN_TIME - 1);
      YELLOW:  return 4'(YELLOW_TIME - 1);
      default: return 4'(RED_TIME - 1);
    endcase
  endfunction

  assign legal    = (light == RED) || (light == YELLOW) || (light == GREEN);
  assign tick_raw = (div_q == DIV_LAST);
  // Gated so tick reads 0 while reset is held, even when TICK_DIV=1.
  assign tick     = rst & tick_raw;
  assign fault    = (state_q == FAULT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    timer_d  = timer;
    expire_d = 1'b0;
    prev_d   = prev_q;
    div_d    = tick_raw ? 16'd0 : div_q + 16'd1;
`ifdef PED_EXTEND_EN
    used_d   = used_q;
    ped_sum  = 5'd0;
`endif
    if (!legal) begin
      state_d = FAULT;
      timer_d = 4'd0;
    end else if (light != prev_q || state_q == FAULT) begin
      // A legal light after FAULT reloads even if it matches prev_light.
      prev_d  = light;
      timer_d = load_val(light);
      div_d   = 16'd0;
      state_d = COUNT;
`ifdef PED_EXTEND_EN
      used_d  = 1'b0;
`endif
    end else if (state_q == COUNT) begin
`ifdef PED_EXTEND_EN
      if (ped_req && prev_q == GREEN && !used_q) begin
        ped_sum = 5'(timer) - 5'((tick_raw && timer != 4'd0) ? 1 : 0) + 5'(PED_EXTRA);
        timer_d = (ped_sum > 5'd15) ? 4'd15 : ped_sum[3:0];
        used_d  = 1'b1;
      end else
`endif
      if (timer == 4'd0) begin
        expire_d = 1'b1;
        state_d  = HOLD;
      end else if (tick_raw) begin
        timer_d = timer - 4'd1;
        if (timer == 4'd1) begin
          expire_d = 1'b1;
          state_d  = HOLD;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COUNT;
      timer   <= 4'(RED_TIME - 1);
      expire  <= 1'b0;
      prev_q  <= RED;
      div_q   <= 16'd0;
`ifdef PED_EXTEND_EN
      used_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer   <= timer_d;
      expire  <= expire_d;
      prev_q  <= prev_d;
      div_q   <= div_d;
`ifdef PED_EXTEND_EN
      used_q  <= used_d;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: two instances (TICK_DIV=1 and TICK_DIV=4) against an arithmetic phase model.
// The model tracks edges since the last load; remaining = max(0, DUR-1 - edges/TICK_DIV).
module tb_traffic_phase_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light = 3'b100;
  logic [3:0] o_timer  [2];
  logic       o_expire [2];
  logic       o_tick   [2];
  logic       o_fault  [2];
`ifdef PED_EXTEND_EN
  logic       ped_req = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model state per instance.
  int         m_n   [2];
  int         m_dur [2];
  logic [2:0] m_prev[2];
  bit         m_flt [2];
  bit         m_exp [2];

  always #5 clk = ~clk;

  traffic_phase_timer #(.TICK_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .light(light),
`ifdef PED_EXTEND_EN
    .ped_req(1'b0),
`endif
    .timer(o_timer[0]), .expire(o_expire[0]), .tick(o_tick[0]), .fault(o_fault[0])
  );

  traffic_phase_timer #(.TICK_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .light(light),
`ifdef PED_EXTEND_EN
    .ped_req(ped_req),
`endif
    .timer(o_timer[1]), .expire(o_expire[1]), .tick(o_tick[1]), .fault(o_fault[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit is_legal(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  function automatic int dur_of(input logic [2:0] l);
    return (l == 3'b010) ? 2 : 3;
  endfunction

  function automatic int exp_timer(input int i);
    int v;
    if (m_flt[i]) return 0;
    v = m_dur[i] - 1 - m_n[i] / div_of(i);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic bit exp_tick(input int i);
    return (m_n[i] % div_of(i)) == div_of(i) - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_dur[i] = 3; m_prev[i] = 3'b100; m_flt[i] = 1'b0; m_exp[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [2:0] l);
    for (int i = 0; i < 2; i++) begin
      m_exp[i] = 1'b0;
      if (!is_legal(l)) begin
        m_flt[i] = 1'b1;
      end else if (l != m_prev[i] || m_flt[i]) begin
        m_prev[i] = l; m_dur[i] = dur_of(l); m_n[i] = 0; m_flt[i] = 1'b0;
      end else begin
        m_n[i]++;
        m_exp[i] = (m_n[i] == ((m_dur[i] == 1) ? 1 : (m_dur[i] - 1) * div_of(i)));
      end
    end
  endtask

  // Apply a light value, take one edge, advance the model and settle for sampling.
  task automatic drive(input logic [2:0] l);
    light = l;
    @(posedge clk);
    model_edge(l);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    light = 3'b100;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_timer[i] !== 4'd2 || o_expire[i] !== 1'b0 || o_fault[i] !== 1'b0 || o_tick[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got timer=%0d expire=%b fault=%b tick=%b, want 2/0/0/0",
                 i, o_timer[i], o_expire[i], o_fault[i], o_tick[i]);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(3'b100);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_timer[i] !== 4'(exp_timer(i)) || o_expire[i] !== m_exp[i]) begin
          errors++;
          $display("FAIL count_hold[%0d] cyc%0d: got timer=%0d expire=%b, want %0d/%b",
                   i, c, o_timer[i], o_expire[i], exp_timer(i), m_exp[i]);
        end
      end
    end
    // Mid-phase asynchronous reset: immediate return, no expire.
    drive(3'b001);
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_timer[i] !== 4'd2 || o_expire[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset[%0d]: got timer=%0d expire=%b, want 2/0", i, o_timer[i], o_expire[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_phase();
    logic [2:0] seq [3] = '{3'b001, 3'b010, 3'b100};
    int npulse;
    for (int p = 0; p < 3; p++) begin
      npulse = 0;
      for (int c = 0; c < 4; c++) begin
        drive(seq[p]);
        if (o_expire[0] === 1'b1) npulse++;
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (o_timer[i] !== 4'(exp_timer(i)) || o_expire[i] !== m_exp[i]) begin
            errors++;
            $display("FAIL phase[%0d] light=%b cyc%0d: got timer=%0d expire=%b, want %0d/%b",
                     i, seq[p], c, o_timer[i], o_expire[i], exp_timer(i), m_exp[i]);
          end
        end
      end
      checks++;
      if (npulse != 1) begin
        errors++;
        $display("FAIL expire_count light=%b: got %0d pulses, want 1", seq[p], npulse);
      end
    end
  endtask

  task automatic test_prescaler();
    int nticks = 0;
    for (int c = 0; c < 16; c++) begin
      drive(3'b001);
      if (o_tick[1] === 1'b1) nticks++;
      checks++;
      if (o_timer[1] !== 4'(exp_timer(1)) || o_tick[1] !== exp_tick(1) || o_expire[1] !== m_exp[1]) begin
        errors++;
        $display("FAIL prescaler cyc%0d: got timer=%0d tick=%b expire=%b, want %0d/%b/%b",
                 c, o_timer[1], o_tick[1], o_expire[1], exp_timer(1), exp_tick(1), m_exp[1]);
      end
    end
    checks++;
    if (nticks != 4) begin
      errors++;
      $display("FAIL tick_count: got %0d, want 4", nticks);
    end
  endtask

  task automatic test_fault_early();
    logic [2:0] seq [6] = '{3'b011, 3'b000, 3'b001, 3'b001, 3'b010, 3'b111};
    for (int c = 0; c < 6; c++) begin
      drive(seq[c]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_timer[i] !== 4'(exp_timer(i)) || o_fault[i] !== m_flt[i] || o_expire[i] !== m_exp[i]) begin
          errors++;
          $display("FAIL fault_early[%0d] light=%b: got timer=%0d fault=%b expire=%b, want %0d/%b/%b",
                   i, seq[c], o_timer[i], o_fault[i], o_expire[i], exp_timer(i), m_flt[i], m_exp[i]);
        end
      end
    end
    // Returning to the pre-fault light still reloads.
    drive(3'b010);
    checks++;
    if (o_timer[0] !== 4'd1 || o_fault[0] !== 1'b0) begin
      errors++;
      $display("FAIL fault_exit_same: got timer=%0d fault=%b, want 1/0", o_timer[0], o_fault[0]);
    end
  endtask

  task automatic test_hold_saturate();
    for (int c = 0; c < 25; c++) begin
      drive(3'b100);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_timer[i] !== 4'(exp_timer(i)) || o_expire[i] !== m_exp[i]) begin
          errors++;
          $display("FAIL hold_sat[%0d] cyc%0d: got timer=%0d expire=%b, want %0d/%b",
                   i, c, o_timer[i], o_expire[i], exp_timer(i), m_exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] cur = 3'b100;
    logic [2:0] legal_set [3] = '{3'b100, 3'b010, 3'b001};
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      if (r >= 97)      cur = 3'($urandom_range(0, 7));
      else if (r >= 85) cur = legal_set[$urandom_range(0, 2)];
      else if (!is_legal(cur)) cur = legal_set[$urandom_range(0, 2)];
      drive(cur);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_timer[i] !== 4'(exp_timer(i)) || o_expire[i] !== m_exp[i] || o_fault[i] !== m_flt[i] ||
            (!m_flt[i] && o_tick[i] !== exp_tick(i))) begin
          errors++;
          $display("FAIL random[%0d] cyc%0d light=%b: got timer=%0d expire=%b fault=%b tick=%b, want %0d/%b/%b/%b",
                   i, c, cur, o_timer[i], o_expire[i], o_fault[i], o_tick[i],
                   exp_timer(i), m_exp[i], m_flt[i], exp_tick(i));
        end
      end
    end
  endtask

`ifdef PED_EXTEND_EN
  task automatic test_ped();
    logic [3:0] want [3] = '{4'd4, 4'd4, 4'd2};
    logic [2:0] lts  [3] = '{3'b001, 3'b001, 3'b100};
    drive(3'b100);
    drive(3'b001);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        ped_req = 1'b0;
        drive(3'b100);
      end
      ped_req = 1'b1;
      drive(lts[c]);
      ped_req = 1'b0;
      checks++;
      if (o_timer[1] !== want[c]) begin
        errors++;
        $display("FAIL ped step%0d: got timer=%0d, want %0d", c, o_timer[1], want[c]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_phase();
    test_prescaler();
    test_fault_early();
    test_hold_saturate();
    test_random();
`ifdef PED_EXTEND_EN
    test_ped();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
